// File: rtl/sram_1p_march_bist.sv
// March C- self-test engine for a single-port SRAM macro with BIST port.
// Walks the six March C- elements over all 2^P_ADDR_WIDTH words, issuing one
// macro operation per clock. Read data is compared P_READ_LATENCY edges after
// the macro's capture edge. The first miscompare is recorded for diagnosis.
//
// Handshake: A_BIST_START is a level request. It is accepted only in IDLE or
// DONE, on the first clock edge that samples it high. BUSY then stays high
// until the edge that raises DONE, and DONE stays high until the next
// accepted start. Inputs are never back-pressured.
module sram_1p_march_bist #(
  parameter int P_DATA_WIDTH   = 16,
  parameter int P_ADDR_WIDTH   = 12,
  parameter int P_READ_LATENCY = 1
) (
  input  logic                    A_CLK,
  input  logic                    A_RST_N,
  input  logic                    A_BIST_START,
  input  logic                    A_BIST_MODE,
  output logic                    A_BIST_BUSY,
  output logic                    A_BIST_DONE,
  output logic                    A_BIST_FAIL,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR,
  output logic [2:0]              A_BIST_FAIL_ELEM,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam int DCW = (P_READ_LATENCY > 1) ? $clog2(P_READ_LATENCY) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(P_READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state;
  logic                    mode_q;
  logic [2:0]              elem_q;
  logic                    phase_q;     // 0 = read half, 1 = write half of r/w elements
  logic [DCW-1:0]          drain_cnt;

  logic                    pipe_vld  [P_READ_LATENCY];
  logic [P_DATA_WIDTH-1:0] pipe_exp  [P_READ_LATENCY];
  logic [P_ADDR_WIDTH-1:0] pipe_addr [P_READ_LATENCY];
  logic [2:0]              pipe_elem [P_READ_LATENCY];

  logic [2:0]              nxt_elem;
  logic                    nxt_phase;
  logic [P_ADDR_WIDTH-1:0] nxt_addr;
  logic                    nxt_write;
  logic                    last_op;
  logic                    miscompare;
  logic [P_DATA_WIDTH-1:0] rd_exp;

  // Background word: solid, or checkerboard with bit i = i[0] ^ addr[0]; val inverts it.
  function automatic logic [P_DATA_WIDTH-1:0] bg(input logic val,
                                                 input logic [P_ADDR_WIDTH-1:0] a,
                                                 input logic m);
    logic [P_DATA_WIDTH-1:0] pat;
    pat = '0;
    for (int i = 0; i < P_DATA_WIDTH; i++) pat[i] = m & (i[0] ^ a[0]);
    return val ? ~pat : pat;
  endfunction

  assign A_BIST_BM = '1;

  // Sequencer: derive the operation that follows the one currently presented.
  always_comb begin
    logic rw_elem;
    logic down;
    logic at_end;
    rw_elem   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    at_end    = down ? (A_BIST_ADDR == '0) : (A_BIST_ADDR == ADDR_MAX);
    nxt_elem  = elem_q;
    nxt_phase = 1'b0;
    nxt_addr  = A_BIST_ADDR;
    if (rw_elem && !phase_q) begin
      nxt_phase = 1'b1;
    end else if (at_end) begin
      nxt_elem = elem_q + 3'd1;
      nxt_addr = ((nxt_elem == 3'd3) || (nxt_elem == 3'd4)) ? ADDR_MAX : '0;
    end else begin
      nxt_addr = down ? A_BIST_ADDR - 1'b1 : A_BIST_ADDR + 1'b1;
    end
    nxt_write = (nxt_elem == 3'd0) ? 1'b1 : (nxt_elem == 3'd5) ? 1'b0 : nxt_phase;
    last_op   = (elem_q == 3'd5) && (A_BIST_ADDR == ADDR_MAX);
    // M2 and M4 read "1"; the other reading elements read "0".
    rd_exp    = bg((elem_q == 3'd2) || (elem_q == 3'd4), A_BIST_ADDR, mode_q);
    miscompare = pipe_vld[P_READ_LATENCY-1] && (A_DOUT != pipe_exp[P_READ_LATENCY-1]);
  end

  // Compare pipeline: carry expected data and tag of each issued read to its compare edge.
  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      for (int i = 0; i < P_READ_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_exp[i]  <= '0;
        pipe_addr[i] <= '0;
        pipe_elem[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= A_BIST_MEN & A_BIST_REN;
      pipe_exp[0]  <= rd_exp;
      pipe_addr[0] <= A_BIST_ADDR;
      pipe_elem[0] <= elem_q;
      for (int i = 1; i < P_READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_elem[i] <= pipe_elem[i-1];
      end
    end
  end

  // Control FSM with registered macro-side outputs and fail capture.
  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state            <= S_IDLE;
      mode_q           <= 1'b0;
      elem_q           <= '0;
      phase_q          <= 1'b0;
      drain_cnt        <= '0;
      A_BIST_BUSY      <= 1'b0;
      A_BIST_DONE      <= 1'b0;
      A_BIST_FAIL      <= 1'b0;
      A_BIST_FAIL_ADDR <= '0;
      A_BIST_FAIL_ELEM <= '0;
      A_BIST_EN        <= 1'b0;
      A_BIST_MEN       <= 1'b0;
      A_BIST_WEN       <= 1'b0;
      A_BIST_REN       <= 1'b0;
      A_BIST_ADDR      <= '0;
      A_BIST_DIN       <= '0;
    end else begin
      if (miscompare) begin
        A_BIST_FAIL <= 1'b1;
        if (!A_BIST_FAIL) begin
          A_BIST_FAIL_ADDR <= pipe_addr[P_READ_LATENCY-1];
          A_BIST_FAIL_ELEM <= pipe_elem[P_READ_LATENCY-1];
        end
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (A_BIST_START) begin
            state            <= S_RUN;
            mode_q           <= A_BIST_MODE;
            A_BIST_BUSY      <= 1'b1;
            A_BIST_DONE      <= 1'b0;
            A_BIST_FAIL      <= 1'b0;
            A_BIST_FAIL_ADDR <= '0;
            A_BIST_FAIL_ELEM <= '0;
            A_BIST_EN        <= 1'b1;
            // Operation 0: M0 write "0" to address 0.
            elem_q           <= '0;
            phase_q          <= 1'b0;
            A_BIST_MEN       <= 1'b1;
            A_BIST_WEN       <= 1'b1;
            A_BIST_REN       <= 1'b0;
            A_BIST_ADDR      <= '0;
            A_BIST_DIN       <= bg(1'b0, '0, A_BIST_MODE);
          end
        end
        S_RUN: begin
          if (last_op) begin
            state      <= S_DRAIN;
            drain_cnt  <= '0;
            A_BIST_MEN <= 1'b0;
            A_BIST_WEN <= 1'b0;
            A_BIST_REN <= 1'b0;
          end else begin
            elem_q      <= nxt_elem;
            phase_q     <= nxt_phase;
            A_BIST_ADDR <= nxt_addr;
            A_BIST_WEN  <= nxt_write;
            A_BIST_REN  <= !nxt_write;
            // M1 and M3 write "1"; M0, M2 and M4 write "0".
            if (nxt_write)
              A_BIST_DIN <= bg((nxt_elem == 3'd1) || (nxt_elem == 3'd3), nxt_addr, mode_q);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state       <= S_DONE;
            A_BIST_DONE <= 1'b1;
            A_BIST_BUSY <= 1'b0;
            A_BIST_EN   <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
